xbar_prio_sched: RTL and testbench

Priority scheduler for the TCDM full crossbar when the crossbar is built with external arbiter priorities enabled. It drives one round-robin priority index per target bank from observed master-side request/grant traffic. Each target's pointer advances past the last granted requester. A per-requester starvation guard forces a target's priority to a requester that has waited too long. The block sits beside the crossbar, taps the master-side request, address and grant signals, and feeds the crossbar's external priority input.

---
 rtl/xbar_prio_sched.sv | 119 +++++++++++
 tb/tb_xbar_prio_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_prio_sched.sv
// Round-robin priority scheduler for the TCDM crossbar external priority input.
// Tracks per-target pointers and boosts starving requesters to top priority.
module xbar_prio_sched #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned NumOut       = 4,
  parameter int unsigned StarveThresh = 8,
  parameter int unsigned CntWidth     = $clog2(StarveThresh+1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clr_i,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0][$clog2(NumOut)-1:0]   add_i,
  input  logic [NumIn-1:0]                       gnt_i,
  output logic [NumOut-1:0][$clog2(NumIn)-1:0]   rr_o,
  output logic [NumIn-1:0]                       starve_o,
  output logic [NumOut-1:0]                      boost_o
);

  localparam int unsigned AW = $clog2(NumOut);
  localparam int unsigned IW = $clog2(NumIn);

  localparam logic [0:0] StNormal = 1'b0;
  localparam logic [0:0] StBoost  = 1'b1;

  localparam logic [CntWidth-1:0] Thresh  = CntWidth'(StarveThresh);
  localparam logic [IW-1:0]       LastIdx = IW'(NumIn - 1);

  logic [NumIn-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic [NumOut-1:0][IW-1:0]      ptr_q, ptr_d;
  logic [NumOut-1:0][IW-1:0]      own_q, own_d;
  logic [NumOut-1:0][IW-1:0]      rr_q, rr_d;
  logic [NumOut-1:0]              st_q, st_d;
  logic [IW-1:0]                  own;

  // Starving flags decode straight from the wait counters
  always_comb begin
    for (int j = 0; j < int'(NumIn); j++) begin
      starve_o[j] = (cnt_q[j] == Thresh);
    end
  end

  assign rr_o    = rr_q;
  assign boost_o = st_q;

  // Next-state for wait counters, per-target pointer, boost state and owner
  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    own_d = own_q;
    st_d  = st_q;
    rr_d  = rr_q;
    own   = '0;

    for (int j = 0; j < int'(NumIn); j++) begin
      if (req_i[j] && !gnt_i[j]) begin
        cnt_d[j] = (cnt_q[j] == Thresh) ? cnt_q[j]
                                        : cnt_q[j] + CntWidth'(1);
      end else begin
        cnt_d[j] = '0;
      end
    end

    for (int k = 0; k < int'(NumOut); k++) begin
      if (st_q[k] == StNormal) begin
        for (int j = 0; j < int'(NumIn); j++) begin
          if (req_i[j] && gnt_i[j] && add_i[j] == AW'(k)) begin
            ptr_d[k] = (IW'(j) == LastIdx) ? '0 : IW'(j) + IW'(1);
          end
        end
        // descending scan so the lowest starving index wins
        for (int j = int'(NumIn) - 1; j >= 0; j--) begin
          if (starve_o[j] && req_i[j] && !gnt_i[j] &&
              add_i[j] == AW'(k)) begin
            st_d[k]  = StBoost;
            own_d[k] = IW'(j);
          end
        end
      end else begin
        own = own_q[k];
        if (req_i[own] && add_i[own] == AW'(k)) begin
          if (gnt_i[own]) begin
            st_d[k]  = StNormal;
            ptr_d[k] = (own == LastIdx) ? '0 : own + IW'(1);
          end
        end else begin
          st_d[k] = StNormal;
        end
      end
      rr_d[k] = (st_d[k] == StBoost) ? own_d[k] : ptr_d[k];
    end

    if (clr_i) begin
      cnt_d = '0;
      ptr_d = '0;
      own_d = '0;
      st_d  = '0;
      rr_d  = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ptr_q <= '0;
      own_q <= '0;
      st_q  <= '0;
      rr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      st_q  <= st_d;
      rr_q  <= rr_d;
    end
  end

endmodule

// File: tb/tb_xbar_prio_sched.sv
// Directed bench for xbar_prio_sched with default parameters
// (4 requesters, 4 targets, starvation threshold 8).
module tb_xbar_prio_sched;

  logic            clk;
  logic            rst_n;
  logic            clr;
  logic [3:0]      req;
  logic [3:0][1:0] add;
  logic [3:0]      gnt;
  logic [3:0][1:0] rr;
  logic [3:0]      starve;
  logic [3:0]      boost;

  int checks;
  int failures;

  xbar_prio_sched dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (clr),
    .req_i    (req),
    .add_i    (add),
    .gnt_i    (gnt),
    .rr_o     (rr),
    .starve_o (starve),
    .boost_o  (boost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    req = '0;
    gnt = '0;
    add = '0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rr !== 8'h00) begin
      failures++;
      $display("FAIL reset_rr got %h exp 00", rr);
    end
    checks++;
    if (boost !== 4'h0 || starve !== 4'h0) begin
      failures++;
      $display("FAIL reset_flags got boost=%h starve=%h exp 0/0",
               boost, starve);
    end
    // drive requester 1 into boost on target 0
    req[1] = 1'b1;
    add[1] = 2'd0;
    step(10);
    checks++;
    if (boost[0] !== 1'b1 || rr[0] !== 2'd1) begin
      failures++;
      $display("FAIL pre_rst_boost got boost0=%b rr0=%0d exp 1/1",
               boost[0], rr[0]);
    end
    // asynchronous reset mid-cycle, traffic still active
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rr !== 8'h00 || boost !== 4'h0 || starve !== 4'h0) begin
      failures++;
      $display("FAIL async_rst got rr=%h boost=%h starve=%h exp 0",
               rr, boost, starve);
    end
    step(1);
    rst_n = 1'b1;
    step(10);
    checks++;
    if (boost[0] !== 1'b1 || starve[1] !== 1'b1) begin
      failures++;
      $display("FAIL pre_clr_boost got boost0=%b starve1=%b exp 1/1",
               boost[0], starve[1]);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++;
    if (rr !== 8'h00 || boost !== 4'h0 || starve !== 4'h0) begin
      failures++;
      $display("FAIL clr got rr=%h boost=%h starve=%h exp 0",
               rr, boost, starve);
    end
    idle_inputs();
  endtask

  task automatic test_rotation();
    do_reset();
    step(5);
    req[2] = 1'b1;
    add[2] = 2'd1;
    gnt[2] = 1'b1;
    step(1);
    checks++;
    if (rr[1] !== 2'd3 || rr[0] !== 2'd0) begin
      failures++;
      $display("FAIL rot_3 got rr1=%0d rr0=%0d exp 3/0", rr[1], rr[0]);
    end
    idle_inputs();
    req[3] = 1'b1;
    add[3] = 2'd1;
    gnt[3] = 1'b1;
    step(1);
    checks++;
    if (rr[1] !== 2'd0) begin
      failures++;
      $display("FAIL rot_wrap got rr1=%0d exp 0", rr[1]);
    end
    idle_inputs();
    req[0] = 1'b1;
    add[0] = 2'd2;
    gnt[0] = 1'b1;
    step(1);
    checks++;
    if (rr !== {2'd0, 2'd1, 2'd0, 2'd0}) begin
      failures++;
      $display("FAIL rot_t2 got rr=%h exp %h", rr, 8'h10);
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    req[1] = 1'b1;
    add[1] = 2'd0;
    step(7);
    checks++;
    if (starve[1] !== 1'b0) begin
      failures++;
      $display("FAIL starve_c7 got %b exp 0", starve[1]);
    end
    step(1);
    checks++;
    if (starve[1] !== 1'b1 || boost[0] !== 1'b0) begin
      failures++;
      $display("FAIL starve_c8 got starve1=%b boost0=%b exp 1/0",
               starve[1], boost[0]);
    end
    step(1);
    checks++;
    if (boost[0] !== 1'b1 || rr[0] !== 2'd1) begin
      failures++;
      $display("FAIL boost_c9 got boost0=%b rr0=%0d exp 1/1",
               boost[0], rr[0]);
    end
    step(1);
    gnt[1] = 1'b1;
    step(1);
    checks++;
    if (boost[0] !== 1'b0 || rr[0] !== 2'd2 || starve[1] !== 1'b0) begin
      failures++;
      $display("FAIL exit_c11 got boost0=%b rr0=%0d starve1=%b exp 0/2/0",
               boost[0], rr[0], starve[1]);
    end
    idle_inputs();
  endtask

  task automatic test_tie_concurrency();
    do_reset();
    req[0] = 1'b1;
    add[0] = 2'd2;
    req[3] = 1'b1;
    add[3] = 2'd2;
    req[1] = 1'b1;
    add[1] = 2'd1;
    step(9);
    checks++;
    if (boost !== 4'b0110 || rr[2] !== 2'd0 || rr[1] !== 2'd1) begin
      failures++;
      $display("FAIL tie_boost got boost=%b rr2=%0d rr1=%0d exp 0110/0/1",
               boost, rr[2], rr[1]);
    end
    gnt[0] = 1'b1;
    step(1);
    gnt[0] = 1'b0;
    req[0] = 1'b0;
    checks++;
    if (boost !== 4'b0010 || rr[2] !== 2'd1) begin
      failures++;
      $display("FAIL tie_exit got boost=%b rr2=%0d exp 0010/1",
               boost, rr[2]);
    end
    step(1);
    checks++;
    if (boost !== 4'b0110 || rr[2] !== 2'd3 || rr[1] !== 2'd1) begin
      failures++;
      $display("FAIL tie_next got boost=%b rr2=%0d rr1=%0d exp 0110/3/1",
               boost, rr[2], rr[1]);
    end
    idle_inputs();
  endtask

  task automatic test_abandon();
    do_reset();
    req[1] = 1'b1;
    add[1] = 2'd3;
    gnt[1] = 1'b1;
    step(1);
    idle_inputs();
    checks++;
    if (rr[3] !== 2'd2) begin
      failures++;
      $display("FAIL abn_ptr got rr3=%0d exp 2", rr[3]);
    end
    req[0] = 1'b1;
    add[0] = 2'd3;
    step(9);
    checks++;
    if (boost[3] !== 1'b1 || rr[3] !== 2'd0) begin
      failures++;
      $display("FAIL abn_boost got boost3=%b rr3=%0d exp 1/0",
               boost[3], rr[3]);
    end
    // grant to a non-owner must not move the pointer
    req[2] = 1'b1;
    add[2] = 2'd3;
    gnt[2] = 1'b1;
    step(1);
    req[2] = 1'b0;
    gnt[2] = 1'b0;
    checks++;
    if (boost[3] !== 1'b1 || rr[3] !== 2'd0) begin
      failures++;
      $display("FAIL abn_nonown got boost3=%b rr3=%0d exp 1/0",
               boost[3], rr[3]);
    end
    req[0] = 1'b0;
    step(1);
    checks++;
    if (boost[3] !== 1'b0 || rr[3] !== 2'd2 || starve[0] !== 1'b0) begin
      failures++;
      $display("FAIL abn_drop got boost3=%b rr3=%0d starve0=%b exp 0/2/0",
               boost[3], rr[3], starve[0]);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    int drops;
    drops = 0;
    do_reset();
    req[2] = 1'b1;
    add[2] = 2'd0;
    step(8);
    for (int i = 8; i < 40; i++) begin
      if (starve[2] !== 1'b1) drops++;
      step(1);
    end
    checks++;
    if (drops != 0 || starve[2] !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold got drops=%0d starve2=%b exp 0/1",
               drops, starve[2]);
    end
    checks++;
    if (boost[0] !== 1'b1 || rr[0] !== 2'd2) begin
      failures++;
      $display("FAIL sat_boost got boost0=%b rr0=%0d exp 1/2",
               boost[0], rr[0]);
    end
    gnt[2] = 1'b1;
    step(1);
    checks++;
    if (starve[2] !== 1'b0 || boost[0] !== 1'b0 || rr[0] !== 2'd3) begin
      failures++;
      $display("FAIL sat_gnt got starve2=%b boost0=%b rr0=%0d exp 0/0/3",
               starve[2], boost[0], rr[0]);
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_rotation();
    test_starvation();
    test_tie_concurrency();
    test_abandon();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
